// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x 32-bit general-purpose register file for the single-cycle CPU.
// Two combinational read ports (a1->r1, a2->r2) and one synchronous write port
// (a3/wd/we). Register 0 is hardwired to zero: writes to it are dropped and reads
// of it return zero, even before the first reset.
module regfile_2r1w #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic [AW-1:0] a3,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] regs [DEPTH];

  // The write is gated off for address zero so entry 0 is never loaded with data.
  logic wr_en;
  assign wr_en = we && (a3 != '0);

  // Synchronous reset clears every register and takes priority over a write;
  // otherwise an enabled write updates the addressed register on the rising edge.
  // NOTE: the register array is deliberately reset (the datapath relies on all
  // registers reading zero after reset), so it is built from flops rather than a
  // RAM macro; the reset loop must stay inside the clocked block to remain synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples its inputs at the same edge, independent of statement order.
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[a3] <= wd;
    end
  end

  // Reads are purely combinational with no write bypass; address zero is forced to
  // zero so r0 reads cleanly even while the array holds unknown pre-reset contents.
  assign r1 = (a1 == '0) ? '0 : regs[a1];
  assign r2 = (a2 == '0) ? '0 : regs[a2];

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed self-checking bench for regfile_2r1w.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled after
// the combinational read paths settle, away from the active edge.
module tb_regfile_2r1w;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;

  int checks   = 0;
  int failures = 0;

  regfile_2r1w #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd    (wd),
    .r1    (r1),
    .r2    (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and leave time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-edge write, leaving we deasserted afterwards.
  task automatic write_reg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a3 = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  function automatic logic [DW-1:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : (32'hA5A5_0000 + DW'(i));
  endfunction

  initial begin
    rst_n = 1'b1;
    we    = 1'b0;
    a1    = '0;
    a2    = '0;
    a3    = '0;
    wd    = '0;
    #2;

    // r0 reads zero even before any reset.
    check("pre_reset_r0_r1", r1, 32'h0);
    check("pre_reset_r0_r2", r2, 32'h0);

    // Reset with a competing write: reset must win.
    rst_n = 1'b0;
    we    = 1'b1;
    a3    = 5'd3;
    wd    = 32'hFFFF_FFFF;
    tick();
    rst_n = 1'b1;
    we    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a1 = AW'(i);
      a2 = AW'(31 - i);
      #1;
      check($sformatf("reset_sweep_r1[%0d]", i), r1, 32'h0);
      check($sformatf("reset_sweep_r2[%0d]", 31 - i), r2, 32'h0);
    end

    // Basic write to register 1.
    write_reg(5'd1, 32'h1234_5678);
    a1 = 5'd0;
    a2 = 5'd1;
    #1;
    check("basic_write_r2", r2, 32'h1234_5678);
    check("basic_write_r0", r1, 32'h0);

    // Writes to register 0 are ignored.
    write_reg(5'd0, 32'h8765_4321);
    a1 = 5'd0;
    a2 = 5'd1;
    #1;
    check("r0_protect_r1", r1, 32'h0);
    check("r0_protect_reg1", r2, 32'h1234_5678);

    // we=0 holds contents across several edges.
    a3 = 5'd1;
    wd = 32'hDEAD_BEEF;
    we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("we0_hold_edge%0d", k), r2, 32'h1234_5678);
    end

    // Overwrite while reading the same register: no bypass before the edge.
    a1 = 5'd1;
    a2 = 5'd1;
    a3 = 5'd1;
    wd = 32'hCAFE_F00D;
    we = 1'b1;
    #1;
    check("no_bypass_r1_before", r1, 32'h1234_5678);
    check("no_bypass_r2_before", r2, 32'h1234_5678);
    tick();
    we = 1'b0;
    check("overwrite_r1_after", r1, 32'hCAFE_F00D);
    check("overwrite_r2_after", r2, 32'hCAFE_F00D);

    // Full sweep: distinct value in every register, read back on both ports.
    for (int i = 1; i < 32; i++) begin
      write_reg(AW'(i), 32'hA5A5_0000 + DW'(i));
    end
    for (int i = 0; i < 32; i++) begin
      a1 = AW'(i);
      a2 = AW'(31 - i);
      #1;
      check($sformatf("sweep_r1[%0d]", i), r1, sweep_val(i));
      check($sformatf("sweep_r2[%0d]", 31 - i), r2, sweep_val(31 - i));
    end

    // Reset mid-operation, with a write to the same register on the reset edge.
    write_reg(5'd5, 32'h0000_0055);
    a1 = 5'd5;
    a2 = 5'd31;
    #1;
    check("pre_midreset_reg5", r1, 32'h0000_0055);
    rst_n = 1'b0;
    we    = 1'b1;
    a3    = 5'd5;
    wd    = 32'h0000_0077;
    tick();
    rst_n = 1'b1;
    we    = 1'b0;
    check("midreset_reg5", r1, 32'h0);
    check("midreset_reg31", r2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
